// File: rtl/layer_mac_engine.sv
// Fully connected layer MAC engine: d_out[o] = sat(sum_i W[layer][o][i] * d_in[i] >>> FRAC),
// weights fetched one per req/ack handshake. Define LAYER_MAC_RELU_EN to clamp negative results to zero.
module layer_mac_engine #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int AW    = 20,
    parameter int LW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LW-1:0]         layer_num,
    input  logic [N_IN*DW-1:0]    d_in,
    output logic                  w_req,
    output logic [AW-1:0]         w_addr,
    input  logic                  w_ack,
    input  logic [DW-1:0]         w_data,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*DW-1:0]   d_out
);

    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int PW    = 2 * DW;
    localparam int ACC_W = 2 * DW + $clog2(N_IN) + 1;

    localparam logic [AW-1:0] LAYER_STRIDE = AW'(N_IN * N_OUT);
    localparam logic [AW-1:0] ROW_STRIDE   = AW'(N_IN);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STORE,
        ST_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [IW-1:0]            i_reg, i_next;
    logic [OW-1:0]            o_reg, o_next;
    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic [LW-1:0]            layer_reg;
    logic signed [DW-1:0]     d_in_q_reg  [N_IN];
    logic signed [DW-1:0]     d_out_reg   [N_OUT];

    logic                     capture;
    logic                     store_en;
    logic signed [PW-1:0]     product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DW-1:0]     sat_val;
    logic signed [DW-1:0]     store_val;
    logic [AW-1:0]            addr_calc;

    assign product     = $signed(w_data) * d_in_q_reg[i_reg];
    assign product_ext = {{(ACC_W-PW){product[PW-1]}}, product};
    assign shifted     = acc_reg >>> FRAC;

    always_comb begin
        sat_val = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_val = {1'b1, {(DW-1){1'b0}}};
        end
    end

`ifdef LAYER_MAC_RELU_EN
    assign store_val = sat_val[DW-1] ? '0 : sat_val;
`else
    assign store_val = sat_val;
`endif

    // Address arithmetic is deliberately AW bits wide so oversized layers wrap instead of widening.
    assign addr_calc = AW'(layer_reg) * LAYER_STRIDE + AW'(o_reg) * ROW_STRIDE + AW'(i_reg);

    assign w_req  = (state_reg == ST_REQ);
    assign w_addr = (state_reg == ST_REQ) ? addr_calc : '0;
    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        o_next     = o_reg;
        acc_next   = acc_reg;
        capture    = 1'b0;
        store_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    acc_next   = '0;
                    i_next     = '0;
                    o_next     = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack) begin
                    acc_next = acc_reg + product_ext;
                    if (i_reg == IW'(N_IN - 1)) begin
                        state_next = ST_STORE;
                    end else begin
                        i_next = i_reg + 1'b1;
                    end
                end
            end
            ST_STORE: begin
                store_en = 1'b1;
                acc_next = '0;
                i_next   = '0;
                if (o_reg == OW'(N_OUT - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    o_next     = o_reg + 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            o_reg     <= '0;
            acc_reg   <= '0;
            layer_reg <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            o_reg     <= o_next;
            acc_reg   <= acc_next;
            if (capture) begin
                layer_reg <= layer_num;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_din
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_in_q_reg[gi] <= '0;
                end else if (capture) begin
                    d_in_q_reg[gi] <= d_in[gi*DW +: DW];
                end
            end
        end

        // Each output element holds its value between runs; only its own STORE cycle updates it.
        for (gi = 0; gi < N_OUT; gi++) begin : g_dout
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_out_reg[gi] <= '0;
                end else if (store_en && (o_reg == OW'(gi))) begin
                    d_out_reg[gi] <= store_val;
                end
            end
            assign d_out[gi*DW +: DW] = d_out_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_layer_mac_engine.sv
// Directed bench for layer_mac_engine with N_IN=2, N_OUT=2, Q8.8 data and a wait-state weight responder.
module tb_layer_mac_engine;

    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int DW    = 16;
    localparam int AW    = 20;
    localparam int LW    = 4;

`ifdef LAYER_MAC_RELU_EN
    localparam logic [15:0] EXP_NEG1    = 16'h0000;
    localparam logic [15:0] EXP_NEG_SAT = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG1    = 16'hFF00;
    localparam logic [15:0] EXP_NEG_SAT = 16'h8000;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [LW-1:0]        layer_num;
    logic [N_IN*DW-1:0]   d_in;
    logic                 w_req;
    logic [AW-1:0]        w_addr;
    logic                 w_ack;
    logic [DW-1:0]        w_data;
    logic                 busy;
    logic                 done;
    logic [N_OUT*DW-1:0]  d_out;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:63];
    int          wait_cycles = 0;
    int          wait_cnt = 0;

    logic        prev_wait;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] addr_q [$];

    layer_mac_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(8), .AW(AW), .LW(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_num(layer_num), .d_in(d_in),
        .w_req(w_req), .w_addr(w_addr), .w_ack(w_ack), .w_data(w_data),
        .busy(busy), .done(done), .d_out(d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight responder: acks after wait_cycles idle REQ cycles; garbage data when not acking.
    assign w_ack  = w_req && (wait_cnt >= wait_cycles);
    assign w_data = w_ack ? mem[w_addr[5:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (w_req && !w_ack) wait_cnt <= wait_cnt + 1;
        else                 wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait && w_req) check("addr_stable", 32'(w_addr), 32'(prev_addr));
            if (w_req && w_ack) addr_q.push_back(w_addr);
            prev_wait <= w_req && !w_ack;
            prev_addr <= w_addr;
        end
    end

    task automatic set_weights(input int base, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
        for (int k = 0; k < 64; k++) mem[k] = 16'h0000;
        mem[base]   = w0;
        mem[base+1] = w1;
        mem[base+2] = w2;
        mem[base+3] = w3;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
    endtask

    task automatic check_addrs(input string tag, input int base);
        check({tag, "_naddr"}, 32'(addr_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_addr"}, (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hFFFF_FFFF, 32'(base + k));
        end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [LW-1:0] layer, input logic [15:0] exp0,
                                 input logic [15:0] exp1, input int exp_edges, input int base);
        int edges;
        addr_q.delete();
        @(negedge clk);
        d_in = {d1, d0};
        layer_num = layer;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges);
        check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_dout0"}, 32'(d_out[15:0]), 32'(exp0));
        check({tag, "_dout1"}, 32'(d_out[31:16]), 32'(exp1));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_addrs(tag, base);
        $display("txn %s: d_out=%h edges=%0d", tag, d_out, edges);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int done_count;
        rst_n = 1'b0;
        start = 1'b0;
        d_in = '0;
        layer_num = '0;
        set_weights(0, 16'h0080, 16'h0040, 16'hFE00, 16'h0080);
        #1;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_wreq",  32'(w_req), 32'd0);
        check("reset_waddr", 32'(w_addr), 32'd0);
        check("reset_dout",  d_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic run (ReLU build expects the negative output clamped).
        run_and_check("basic", 16'h0100, 16'h0200, 4'd0, 16'h0100, EXP_NEG1, 6, 0);

        // Layer 3 addressing with three wait states per request.
        set_weights(12, 16'h0080, 16'h0040, 16'hFE00, 16'h0080);
        wait_cycles = 3;
        run_and_check("wait_l3", 16'h0100, 16'h0200, 4'd3, 16'h0100, EXP_NEG1, 18, 12);
        wait_cycles = 0;

        // Positive and negative saturation.
        set_weights(0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
        run_and_check("sat_pos", 16'h7F00, 16'h7F00, 4'd0, 16'h7FFF, 16'h7FFF, 6, 0);
        set_weights(0, 16'h8100, 16'h8100, 16'h8100, 16'h8100);
        run_and_check("sat_neg", 16'h7F00, 16'h7F00, 4'd0, EXP_NEG_SAT, EXP_NEG_SAT, 6, 0);

        // Reset during the second REQ of output 1, then a clean rerun.
        set_weights(0, 16'h0080, 16'h0040, 16'hFE00, 16'h0080);
        @(negedge clk);
        d_in = {16'h0200, 16'h0100};
        layer_num = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_pre_wreq",  32'(w_req),  32'd1);
        check("rst_pre_waddr", 32'(w_addr), 32'd3);
        check("rst_pre_dout0", 32'(d_out[15:0]), 32'h0100);
        rst_n = 1'b0;
        #1;
        check("rst_wreq",  32'(w_req),  32'd0);
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_done",  32'(done),   32'd0);
        check("rst_waddr", 32'(w_addr), 32'd0);
        check("rst_dout",  d_out, 32'd0);
        $display("txn reset_mid_op: w_req=%b busy=%b d_out=%h", w_req, busy, d_out);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_and_check("post_rst", 16'h0100, 16'h0200, 4'd0, 16'h0100, EXP_NEG1, 6, 0);

        // start pulsed while busy with different inputs must be ignored.
        addr_q.delete();
        @(negedge clk);
        d_in = {16'h0200, 16'h0100};
        layer_num = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        d_in = {16'h1234, 16'h4321};
        layer_num = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges);
        check("busy_start_latency", 32'(edges), 32'd4);
        check("busy_start_dout0", 32'(d_out[15:0]), 32'h0100);
        check("busy_start_dout1", 32'(d_out[31:16]), 32'(EXP_NEG1));
        done_count = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) done_count++;
        end
        check("busy_start_extra_done", 32'(done_count), 32'd0);
        check("busy_start_idle", 32'(busy), 32'd0);
        check_addrs("busy_start", 0);
        $display("txn start_while_busy: d_out=%h extra_done=%0d", d_out, done_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_mac_engine.md
Name: layer_mac_engine

Overview:
- Parametrised successor of the single-layer neuron updater: computes d_out[o] = sum_i W[layer][o][i] * d_in[i] for one fully connected layer.
- Uses signed fixed-point data, with separate input and output widths (N_IN, N_OUT).
- Fetches weights one at a time over a req/ack memory port and sequences itself with an explicit FSM.
- Sits between the network controller (start/done, layer_num) and the shared weight ROM/RAM.

Parameters:
- N_IN, 8, number of input neurons (>=1)
- N_OUT, 8, number of output neurons (>=1)
- DW, 16, signed data/weight width, two's complement
- FRAC, 8, fractional bits of the Q format for both data and weights
- AW, 20, weight memory word-address width
- LW, 4, width of layer_num

Ports:
- clk, input, 1, clock; all state changes on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, begin layer evaluation; sampled only in IDLE
- layer_num, input, LW, layer index; captured with start
- d_in, input, N_IN*DW, packed inputs, element i at [i*DW +: DW]; captured with start
- w_req, output, 1, weight read request
- w_addr, output, AW, weight word address
- w_ack, input, 1, weight valid this cycle
- w_data, input, DW, signed weight, valid while w_ack=1
- busy, output, 1, high from the start-sampling edge until the DONE state is left
- done, output, 1, one-cycle completion pulse
- d_out, output, N_OUT*DW, packed outputs, element o at [o*DW +: DW]

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all counters and the accumulator clear.
  - busy=0, done=0, w_req=0, w_addr=0, d_out=0.
  - Takes effect immediately, including mid-operation. The in-flight request is abandoned and a late w_ack is ignored.
- States:
  - IDLE: waits for start.
  - REQ: fetches one weight.
  - STORE: writes one output.
  - DONE: signals completion.
- IDLE:
  - If start=1, capture d_in and layer_num, clear the accumulator, set o=0 and i=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - w_req=1 and w_addr = layer_num*N_IN*N_OUT + o*N_IN + i, computed to AW bits, truncated.
  - w_addr stays stable while w_ack=0; wait states are unlimited.
  - On w_ack=1, add w_data*d_in_q[i] to the accumulator in the same cycle. Ack in the first REQ cycle is legal, giving one weight per clock.
  - After the ack: if i==N_IN-1 go to STORE, else i+1 and stay in REQ.
  - w_req=0 in every state other than REQ.
- STORE:
  - d_out[o] = sat_DW(acc >>> FRAC), using an arithmetic shift (floor).
  - Then clear the accumulator and set i=0.
  - If o==N_OUT-1 go to DONE, else o+1 and go to REQ.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - Products are full 2*DW-bit signed.
  - Accumulator width is 2*DW + clog2(N_IN) + 1, so it never overflows.
  - Saturation clamps to the range [-2^(DW-1), 2^(DW-1)-1].
- Latency with zero-wait ack: done is high during the cycle beginning N_OUT*(N_IN+1) edges after the start-sampling edge.
- d_out elements are updated only in STORE and otherwise hold their value, including across operations.
- start while busy: ignored; no queuing.
- start held high through DONE: a new run begins in the IDLE cycle immediately after DONE.
- Changes to d_in or layer_num while busy have no effect, because the captured copies are used.

Optional Feature:
- Macro: LAYER_MAC_RELU_EN.
- Defined: STORE writes max(0, sat_DW(acc >>> FRAC)).
- Undefined: the saturated result is written unchanged.
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Setup for all scenarios unless stated: N_IN=2, N_OUT=2, DW=16, FRAC=8, zero-wait ack.
1. Basic run:
   - d_in={0x0100, 0x0200}, layer_num=0, weights {0x0080, 0x0040, 0xFE00, 0x0080} at addresses 0..3.
   - Expect d_out={0x0100, 0xFF00}, w_addr sequence 0,1,2,3, and done 6 edges after start.
2. ReLU build:
   - Same stimulus as scenario 1 with LAYER_MAC_RELU_EN defined.
   - Expect d_out={0x0100, 0x0000}.
3. Addressing and wait states:
   - layer_num=3, w_ack delayed 3 cycles per request.
   - Expect w_addr sequence 12,13,14,15, each held stable while waiting, and the same numeric results as scenario 1.
4. Saturation:
   - d_in={0x7F00, 0x7F00}, all weights 0x7F00.
   - Expect d_out={0x7FFF, 0x7FFF}.
   - With all weights 0x8100, expect d_out={0x8000, 0x8000}.
5. Reset mid-operation:
   - Assert rst_n=0 during the second REQ of output 1.
   - Expect w_req, busy, done and d_out to be 0 immediately.
   - After release, a fresh start reproduces scenario 1 exactly.
6. start while busy:
   - Pulse start while busy with different d_in.
   - Expect it ignored, results per the original capture, and a single done pulse.
